// File: rtl/ibuffer.sv
// ibuffer: circular instruction FIFO between the fetch line return path and decode.
// Latency: a line completing in cycle T shows its first instruction on ibuf_inst in T+1.
// Backpressure: decode stalls via ibuf_inst_ready; fetch is throttled by the registered fetch_inst.
//
// Ports:
//   clock, reset_n           clock and synchronous active-low reset
//   redirect_valid           flush request; empties the buffer and discards in-flight line
//   pc_req_handshake         a fetch request was accepted by the icache this cycle
//   pc_operation_done        a fetch line (line_data / line_pc) is returned this cycle
//   line_data, line_pc       returned line (4 slots) and its request PC; line_pc[3:2] = first valid slot
//   fetch_inst               room for another line, including a line still in flight
//   ibuf_inst_valid/_ready   head-of-queue handshake towards decode
//   ibuf_inst, ibuf_pc       head instruction and its PC
//   ibuf_count               number of occupied entries
//   perf_*                   optional counters, present only when IBUF_PERF_CNT_EN is defined
module ibuffer #(
    parameter int DEPTH  = 16,
    parameter int INST_W = 32
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     redirect_valid,
    input  logic                     pc_req_handshake,
    input  logic                     pc_operation_done,
    input  logic [4*INST_W-1:0]      line_data,
    input  logic [63:0]              line_pc,
    output logic                     fetch_inst,
    output logic                     ibuf_inst_valid,
    output logic [INST_W-1:0]        ibuf_inst,
    output logic [63:0]              ibuf_pc,
    input  logic                     ibuf_inst_ready,
    output logic [$clog2(DEPTH):0]   ibuf_count
`ifdef IBUF_PERF_CNT_EN
    ,
    output logic [31:0]              perf_stall_cycles,
    output logic [31:0]              perf_flush_cnt,
    output logic [15:0]              perf_drop_cnt
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [63:0]       pc;
    } entry_t;

    entry_t          mem [DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [CW-1:0]   count;
    logic            outstanding;
    logic            drop_pending;

    logic [1:0]      first_slot;
    logic [2:0]      line_n;
    logic [CW-1:0]   free_slots;
    logic            line_accept;
    logic            overflow;
    logic            do_write;
    logic            do_pop;

    logic [CW-1:0]   count_next;
    logic            outstanding_next;
    logic            drop_next;
    logic            fetch_next;
    logic [CW-1:0]   reserve;

    // Low PC bits address bytes within an instruction and carry no information here.
    logic            unused_pc_bits;
    assign unused_pc_bits = ^line_pc[1:0];

    // ------------------------------------------------------------------
    // Line acceptance
    // ------------------------------------------------------------------
    assign first_slot  = line_pc[3:2];
    assign line_n      = 3'd4 - {1'b0, first_slot};
    assign free_slots  = DEPTH_C - count;

    // A line is taken only when no flush is in progress this cycle and it is
    // not the stale response to a request that a redirect already cancelled.
    assign line_accept = pc_operation_done && !redirect_valid && !drop_pending;
    assign overflow    = free_slots < CW'(line_n);
    assign do_write    = line_accept && !overflow;

    // A pop coinciding with a redirect is meaningless: the buffer is emptied anyway.
    assign do_pop      = ibuf_inst_valid && ibuf_inst_ready && !redirect_valid;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        count_next       = count;
        outstanding_next = outstanding;
        drop_next        = drop_pending;
        reserve          = '0;
        fetch_next       = 1'b0;

        if (redirect_valid) begin
            count_next = '0;
        end else begin
            count_next = count
                       + (do_write ? CW'(line_n) : '0)
                       - (do_pop   ? CW'(1)      : '0);
        end

        // A new request takes priority: a handshake in the same cycle as a
        // completion (or a redirect) means another line is now in flight.
        if (pc_req_handshake) begin
            outstanding_next = 1'b1;
        end else if (pc_operation_done || redirect_valid) begin
            outstanding_next = 1'b0;
        end

        // Any completion consumes a pending drop. A redirect that leaves a
        // request in flight arms the drop so its late response is discarded.
        if (pc_operation_done) begin
            drop_next = 1'b0;
        end
        if (redirect_valid && outstanding && !pc_operation_done) begin
            drop_next = 1'b1;
        end

        // Reserve space for a line that is already requested so it always fits.
        reserve    = outstanding_next ? CW'(4) : '0;
        fetch_next = !redirect_valid && ((DEPTH_C - count_next) >= (CW'(4) + reserve));
    end

    // ------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            count        <= '0;
            outstanding  <= 1'b0;
            drop_pending <= 1'b0;
            fetch_inst   <= 1'b0;
        end else begin
            count        <= count_next;
            outstanding  <= outstanding_next;
            drop_pending <= drop_next;
            fetch_inst   <= fetch_next;

            if (redirect_valid) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (do_pop) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
                if (do_write) begin
                    wr_ptr <= wr_ptr + PW'(line_n);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Storage: slots first_slot..3 land at wr_ptr onwards in slot order.
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset_n && do_write) begin
            for (int k = 0; k < 4; k++) begin
                if (2'(k) >= first_slot) begin
                    mem[wr_ptr + PW'(k) - PW'(first_slot)] <= '{
                        inst: line_data[k*INST_W +: INST_W],
                        pc:   {line_pc[63:4], 2'(k), 2'b00}
                    };
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Decode-side outputs
    // ------------------------------------------------------------------
    assign ibuf_inst_valid = (count != '0);
    assign ibuf_inst       = mem[rd_ptr].inst;
    assign ibuf_pc         = mem[rd_ptr].pc;
    assign ibuf_count      = count;

    // ------------------------------------------------------------------
    // Optional performance counters (saturating)
    // ------------------------------------------------------------------
`ifdef IBUF_PERF_CNT_EN
    logic line_dropped;
    assign line_dropped = pc_operation_done && !do_write;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            perf_stall_cycles <= '0;
            perf_flush_cnt    <= '0;
            perf_drop_cnt     <= '0;
        end else begin
            if (!fetch_inst && !redirect_valid && (perf_stall_cycles != '1)) begin
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            end
            if (redirect_valid && (perf_flush_cnt != '1)) begin
                perf_flush_cnt <= perf_flush_cnt + 32'd1;
            end
            if (line_dropped && (perf_drop_cnt != '1)) begin
                perf_drop_cnt <= perf_drop_cnt + 16'd1;
            end
        end
    end
`else
    // Counters compiled out; buffer behaviour is unchanged.
`endif

    // ------------------------------------------------------------------
    // Checks
    // ------------------------------------------------------------------
    // The fetch_inst reservation makes overflow impossible; firing here means
    // the PC control stage issued a request without room for its line.
    a_no_overflow: assert property (@(posedge clock) disable iff (!reset_n)
        !(line_accept && overflow));

    a_count_bound: assert property (@(posedge clock) disable iff (!reset_n)
        count <= DEPTH_C);

endmodule
